// File: rtl/ampa_apb_master.sv
// APB requester: valid/ready command port in, APB P_* bus out, valid/ready response port back.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module ampa_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on the rising edge where valid & ready are both 1;
  // valid never depends on ready, and payload is held stable while valid is high.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   timed_out;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      wait_cnt <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt <= '0;
    end else if (state_q == ACCESS && !P_ready && wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Abort on the TIMEOUT_CYCLES-th wait cycle; P_ready on that cycle still completes normally.
  assign timed_out = (state_q == ACCESS) && !P_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      rsp_timeout <= 1'b0;
    end else if (state_q == ACCESS && (P_ready || timed_out)) begin
      rsp_timeout <= !P_ready;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (P_ready || timed_out) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    P_selx    = (state_q == SETUP) || (state_q == ACCESS);
    P_enable  = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
    dbg_state = state_q;
  end

  // Bus payload is loaded only on command acceptance and otherwise keeps its last value.
  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      P_addr  <= '0;
      P_write <= 1'b0;
      P_wdata <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      P_addr  <= cmd_addr;
      P_write <= cmd_write;
      P_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (P_ready) begin
        rsp_rdata  <= P_write ? '0 : P_rdata;
        rsp_slverr <= P_slverr;
      end else if (timed_out) begin
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ampa_apb_master.sv
// Directed bench for ampa_apb_master: a timeline model predicts bus phases and responses per cycle.
// Build with APB_MASTER_TIMEOUT_EN defined to also exercise the watchdog.
module tb_ampa_apb_master;

  localparam int TO = 8;
  localparam int BIG = 1000000;

  logic        P_clk = 1'b0;
  logic        P_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] P_addr;
  logic        P_selx;
  logic        P_enable;
  logic        P_write;
  logic [31:0] P_wdata;
  logic        P_ready = 1'b0;
  logic        P_slverr = 1'b0;
  logic [31:0] P_rdata = '0;
  logic [1:0]  dbg_state;

  ampa_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
    .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 P_clk = ~P_clk;

  int cyc = 0;
  always @(posedge P_clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_q[$];   // {timeout, slverr, rdata}
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  int          m_weff = 0;
  int          m_resp = 0;
  logic [31:0] m_addr = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_wdata = '0;

  // Values the driver observes, compared later against hand-computed literals.
  int          acc_e, hs_e, rv_edge;
  logic [33:0] got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge P_clk) begin : compare
    int  d;
    bit  busy_now, sel, en, rv;
    if (!P_rst) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_selx", P_selx, 0);
      chk("rst_enable", P_enable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_addr", P_addr, 0);
      chk("rst_wdata", P_wdata, 0);
      chk("rst_write", P_write, 0);
      chk("rst_rsp", {rsp_timeout, rsp_slverr, rsp_rdata[29:0]}, 0);
    end else begin
      busy_now = m_busy && (cyc < m_resp);
      d   = cyc - m_acc;
      sel = busy_now && (d <= 1 + m_weff);
      en  = busy_now && (d >= 1) && (d <= 1 + m_weff);
      rv  = busy_now && (d >= 2 + m_weff);
      chk("cmd_ready", cmd_ready, !busy_now);
      chk("P_selx", P_selx, sel);
      chk("P_enable", P_enable, en);
      chk("rsp_valid", rsp_valid, rv);
      chk("P_addr", P_addr, m_addr);
      chk("P_write", P_write, m_write);
      chk("P_wdata", P_wdata, m_wdata);
      if (rv) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
          chk("rsp_slverr", rsp_slverr, exp_q[0][32]);
          chk("rsp_timeout", rsp_timeout, exp_q[0][33]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge P_clk);
    #1;
    if (rsp_valid === 1'b1 && rv_edge < 0) rv_edge = cyc;
  endtask

  // Call 1 time unit after a rising edge with the DUT idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input bit err,
                      input int bp, input bit v_bp);
    bit to;
    int w_eff;
    to = 1'b0;
    w_eff = waits;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TO) begin
      to = 1'b1;
      w_eff = TO - 1;
    end
`endif
    rv_edge = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    step();
    acc_e = cyc;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
    m_busy = 1'b1; m_acc = cyc; m_weff = w_eff; m_resp = cyc + 3 + w_eff + bp;
    m_addr = addr; m_write = wr; m_wdata = wdata;
    exp_q.push_back({to, to | err, (to || wr) ? 32'h0 : rdata});
    // A ready pulse during SETUP must be ignored.
    if (waits > 0) begin P_ready = 1'b1; P_rdata = '1; P_slverr = 1'b1; end
    repeat (1 + w_eff) begin
      step();
      P_ready = 1'b0; P_rdata = $urandom; P_slverr = 1'b0;
    end
    if (!to) begin P_ready = 1'b1; P_rdata = rdata; P_slverr = err; end
    step();
    P_ready = 1'b0; P_rdata = $urandom; P_slverr = $urandom_range(0, 1);
    got = {rsp_timeout, rsp_slverr, rsp_rdata};
    if (v_bp) begin cmd_valid = 1'b1; cmd_addr = 32'hBAD0_0000; cmd_wdata = 32'hBAD1; end
    repeat (bp) step();
    rsp_ready = 1'b1;
    step();
    hs_e = cyc;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    void'(exp_q.pop_front());
    m_busy = 1'b0;
  endtask

  task automatic do_reset_model();
    P_rst = 1'b0;
    m_busy = 1'b0; exp_q.delete();
    m_addr = '0; m_write = 1'b0; m_wdata = '0;
  endtask

  // Start a read that never gets P_ready, stall n ACCESS cycles, then reset mid-transfer.
  task automatic xfer_reset(input logic [31:0] addr, input int n_access);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = 32'h0;
    step();
    cmd_valid = 1'b0;
    m_busy = 1'b1; m_acc = cyc; m_weff = BIG; m_resp = cyc + BIG;
    m_addr = addr; m_write = 1'b0; m_wdata = 32'h0;
    P_ready = 1'b0;
    repeat (1 + n_access) step();
    chk("stall_enable", P_enable, 1);
    chk("stall_no_rsp", rsp_valid, 0);
    #1;
    do_reset_model();
    #1;
    chk("async_rst_selx", P_selx, 0);
    chk("async_rst_enable", P_enable, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    repeat (2) step();
    P_rst = 1'b1;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset_model();
    repeat (3) @(posedge P_clk);
    #1;
    P_rst = 1'b1;
    step();

    // 1: write, zero wait
    xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 1'b0);
    chk("t1_rsp", got[31:0], 32'h0);
    chk("t1_err", got[33:32], 2'b00);
    chk("t1_lat", rv_edge - acc_e, 2);

    // 2: read, two wait states
    xfer(1'b0, 32'h8, 32'h0, 2, 32'h12345678, 1'b0, 0, 1'b0);
    chk("t2_rdata", got[31:0], 32'h12345678);
    chk("t2_lat", rv_edge - acc_e, 4);

    // 3: response backpressure with a pending command, then back-to-back accept
    xfer(1'b0, 32'h10, 32'h0, 1, 32'hA5A50001, 1'b0, 4, 1'b1);
    chk("t3_rdata", got[31:0], 32'hA5A50001);
    begin
      int prev_hs;
      prev_hs = hs_e;
      xfer(1'b1, 32'h14, 32'h0BADF00D, 0, 32'hFFFF0000, 1'b0, 0, 1'b0);
      chk("t3_next_accept", acc_e, prev_hs + 1);
    end

    // 4: completer error on write, and on a read with waits
    xfer(1'b1, 32'h1C, 32'h11, 0, 32'h77, 1'b1, 0, 1'b0);
    chk("t4_err", got[33:32], 2'b01);
    chk("t4_rdata", got[31:0], 32'h0);
    xfer(1'b0, 32'h20, 32'h0, 3, 32'hCAFE0003, 1'b1, 1, 1'b0);
    chk("t4_rd_err", got, {2'b01, 32'hCAFE0003});

    // 5: reset mid-ACCESS, then a normal transfer
    xfer_reset(32'h24, 4);
    xfer(1'b0, 32'h28, 32'h0, 0, 32'h0000BEEF, 1'b0, 0, 1'b0);
    chk("t5_rdata", got[31:0], 32'h0000BEEF);

`ifdef APB_MASTER_TIMEOUT_EN
    // 6: ready on the last allowed wait cycle wins; one more wait aborts
    xfer(1'b0, 32'h30, 32'h0, TO - 1, 32'h13579BDF, 1'b0, 0, 1'b0);
    chk("t6_edge_ok", got, {2'b00, 32'h13579BDF});
    chk("t6_edge_lat", rv_edge - acc_e, TO + 1);
    xfer(1'b0, 32'h34, 32'h0, TO, 32'h2468ACE0, 1'b0, 2, 1'b0);
    chk("t6_timeout", got, {2'b11, 32'h0});
    chk("t6_to_lat", rv_edge - acc_e, TO + 1);
`else
    // 6: without the watchdog ACCESS holds indefinitely
    xfer_reset(32'h34, 110);
`endif

    // mixed directed traffic
    for (int i = 0; i < 6; i++) begin
      xfer(i[0], 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), i % 4, 32'hD000 + 32'(i),
           (i == 4), i % 3, i[1]);
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
